// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the instruction sequencer: opcodes, register selects, ALU ops,
// FSM states and the bundled control word driven into the datapath.
package ctrl_sequencer_pkg;

    localparam int unsigned WordW = 8;

    typedef logic [WordW-1:0] word_t;

    typedef enum logic [1:0] {RegA, RegB, RegC, RegD} e_reg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_MOV   = 4'h6,
        OP_LW    = 4'h7,
        OP_LI    = 4'h8,
        OP_ADDI  = 4'h9,
        OP_JMP   = 4'hA,
        OP_BEQ   = 4'hB,
        OP_ILL_C = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_HALT  = 4'hF
    } e_opcode;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASSB
    } e_alu_op;

    typedef enum logic [1:0] {S_DECODE, S_IMM, S_HALT} e_ctrl_state;

    typedef struct packed {
        e_reg    rs;
        e_reg    rt;
        word_t   imm;
        e_alu_op alu_op;
        logic    reg_wr;
        logic    pc_src;
        logic    alu_src;
        logic    mem_to_reg;
    } s_ctrl;

    localparam s_ctrl CTRL_IDLE = '{
        rs:         RegA,
        rt:         RegA,
        imm:        '0,
        alu_op:     ALU_NOP,
        reg_wr:     1'b0,
        pc_src:     1'b0,
        alu_src:    1'b0,
        mem_to_reg: 1'b0
    };

    // ALU function for the register-register group (ADD..XOR, MOV).
    function automatic e_alu_op rr_alu_op(input e_opcode op);
        e_alu_op res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            OP_MOV:  res = ALU_PASSB;
            default: res = ALU_NOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_decoder.sv
// Pure combinational opcode/rs/rt decode into a datapath control word plus
// flags telling the sequencer whether the op needs an operand byte or halts.
module ctrl_sequencer_decoder
    import ctrl_sequencer_pkg::*;
(
    input  e_opcode opcode_i,
    input  e_reg    rs_i,
    input  e_reg    rt_i,
    output s_ctrl   ctrl_o,
    output logic    is_2byte_o,
    output logic    is_halt_o
);

    always_comb begin
        ctrl_o     = CTRL_IDLE;
        is_2byte_o = 1'b0;
        is_halt_o  = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                ctrl_o.rs      = rs_i;
                ctrl_o.rt      = rt_i;
                ctrl_o.alu_op  = rr_alu_op(opcode_i);
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.alu_src = 1'b1;
            end
            OP_LW: begin
                // Address is rs + 0, so srcB comes from the zero immediate.
                ctrl_o.rs         = rs_i;
                ctrl_o.rt         = rt_i;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.reg_wr     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_LI: begin
                ctrl_o.rs     = rs_i;
                ctrl_o.alu_op = ALU_PASSB;
                ctrl_o.reg_wr = 1'b1;
                is_2byte_o    = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.rs     = rs_i;
                ctrl_o.alu_op = ALU_ADD;
                ctrl_o.reg_wr = 1'b1;
                is_2byte_o    = 1'b1;
            end
            OP_JMP: begin
                ctrl_o.pc_src = 1'b1;
                is_2byte_o    = 1'b1;
            end
            OP_BEQ: begin
                // Branch decision itself is made by the sequencer from alu_zero.
                ctrl_o.rs      = rs_i;
                ctrl_o.rt      = rt_i;
                ctrl_o.alu_op  = ALU_SUB;
                ctrl_o.alu_src = 1'b1;
                is_2byte_o     = 1'b1;
            end
            OP_HALT: is_halt_o = 1'b1;
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Decode/sequencing stage feeding the datapath: operand-byte FSM, HALT and imm muxing.
// Optional CTRL_ILLEGAL_TRAP_EN turns opcodes C/D/E into a sticky-flagged halt.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  word_t   instr,
    input  word_t   pc,
    input  logic    alu_zero,
    output e_reg    rs,
    output e_reg    rt,
    output word_t   imm,
    output e_alu_op alu_op,
    output logic    reg_wr,
    output logic    pc_src,
    output logic    alu_src,
    output logic    mem_to_reg,
    output logic    halted,
    output logic    illegal
);

    e_ctrl_state state_q, state_d;
    e_opcode     op_q, op_d;
    e_reg        rs_q, rs_d;
    e_reg        rt_q, rt_d;

    e_opcode dec_op;
    e_reg    dec_rs;
    e_reg    dec_rt;
    s_ctrl   dec_ctrl;
    logic    dec_2byte;
    logic    dec_halt;
    s_ctrl   ctrl;
    logic    beq_issue;
    logic    trap;

    // In S_IMM the instr bus carries the operand, so decode from the latched fields.
    always_comb begin
        dec_op = e_opcode'(instr[7:4]);
        dec_rs = e_reg'(instr[3:2]);
        dec_rt = e_reg'(instr[1:0]);
        if (state_q == S_IMM) begin
            dec_op = op_q;
            dec_rs = rs_q;
            dec_rt = rt_q;
        end
    end

    ctrl_sequencer_decoder u_decoder (
        .opcode_i   (dec_op),
        .rs_i       (dec_rs),
        .rt_i       (dec_rt),
        .ctrl_o     (dec_ctrl),
        .is_2byte_o (dec_2byte),
        .is_halt_o  (dec_halt)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign trap      = (state_q == S_DECODE) &&
                       (e_opcode'(instr[7:4]) inside {OP_ILL_C, OP_ILL_D, OP_ILL_E});
    assign illegal_d = illegal_q | trap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = rst & illegal_q;
`else
    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        ctrl      = CTRL_IDLE;
        beq_issue = 1'b0;
        unique case (state_q)
            S_DECODE: begin
                if (dec_halt || trap) begin
                    // Jump to self keeps pc parked on the halting byte.
                    ctrl.pc_src = 1'b1;
                    ctrl.imm    = pc;
                    state_d     = S_HALT;
                end else if (dec_2byte) begin
                    op_d    = dec_op;
                    rs_d    = dec_rs;
                    rt_d    = dec_rt;
                    state_d = S_IMM;
                end else begin
                    ctrl = dec_ctrl;
                end
            end
            S_IMM: begin
                ctrl      = dec_ctrl;
                ctrl.imm  = instr;
                beq_issue = (op_q == OP_BEQ);
                state_d   = S_DECODE;
            end
            S_HALT: begin
                ctrl.pc_src = 1'b1;
                ctrl.imm    = pc;
            end
            default: state_d = S_DECODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_DECODE;
            op_q    <= OP_NOP;
            rs_q    <= RegA;
            rt_q    <= RegA;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    // Kept apart from the FSM block so alu_zero only reaches pc_src.
    always_comb begin
        rs         = RegA;
        rt         = RegA;
        imm        = '0;
        alu_op     = ALU_NOP;
        reg_wr     = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            rs         = ctrl.rs;
            rt         = ctrl.rt;
            imm        = ctrl.imm;
            alu_op     = ctrl.alu_op;
            reg_wr     = ctrl.reg_wr;
            pc_src     = ctrl.pc_src | (beq_issue & alu_zero);
            alu_src    = ctrl.alu_src;
            mem_to_reg = ctrl.mem_to_reg;
            halted     = (state_q == S_HALT);
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench: sequencer + behavioural datapath + 256x8 ROM; scoreboard of per-cycle expectations.
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    logic    clk;
    logic    rst;
    word_t   instr;
    word_t   pc;
    logic    alu_zero;
    e_reg    rs;
    e_reg    rt;
    word_t   imm;
    e_alu_op alu_op;
    logic    reg_wr;
    logic    pc_src;
    logic    alu_src;
    logic    mem_to_reg;
    logic    halted;
    logic    illegal;

    ctrl_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .pc         (pc),
        .alu_zero   (alu_zero),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .alu_op     (alu_op),
        .reg_wr     (reg_wr),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    word_t rom  [256];
    word_t dmem [256];
    word_t rf_q [4];
    word_t pc_q;
    word_t src_b;
    word_t alu_out;
    word_t wb;

    assign pc    = pc_q;
    assign instr = rom[pc_q];

    always_comb begin
        src_b = alu_src ? rf_q[rt] : imm;
        case (alu_op)
            ALU_ADD:   alu_out = rf_q[rs] + src_b;
            ALU_SUB:   alu_out = rf_q[rs] - src_b;
            ALU_AND:   alu_out = rf_q[rs] & src_b;
            ALU_OR:    alu_out = rf_q[rs] | src_b;
            ALU_XOR:   alu_out = rf_q[rs] ^ src_b;
            ALU_PASSB: alu_out = src_b;
            default:   alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
        wb       = mem_to_reg ? dmem[alu_out] : alu_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= 8'h00;
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
        end else begin
            pc_q <= pc_src ? imm : pc_q + 8'd1;
            if (reg_wr) rf_q[rs] <= wb;
        end
    end

    // Scoreboard
    typedef struct {
        int    cyc;
        string tag;
        int    sel;
        word_t exp;
    } exp_t;

    localparam int SelPc = 0, SelA = 1, SelB = 2, SelC = 3, SelD = 4;
    localparam int SelHalt = 5, SelIll = 6, SelWr = 7;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic word_t obs_of(input int sel);
        case (sel)
            SelPc:   return pc;
            SelA:    return rf_q[0];
            SelB:    return rf_q[1];
            SelC:    return rf_q[2];
            SelD:    return rf_q[3];
            SelHalt: return {7'd0, halted};
            SelIll:  return {7'd0, illegal};
            default: return {7'd0, reg_wr};
        endcase
    endfunction

    task automatic push(input int cyc, input string tag, input int sel, input word_t exp);
        exp_t e;
        e.cyc = cyc;
        e.tag = $sformatf("%s@%0d", tag, cyc);
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_pc_run(input int cyc0, input word_t pc0, input int n, input bit hold);
        for (int k = 0; k < n; k++) begin
            push(cyc0 + k, "pc", SelPc, hold ? pc0 : pc0 + 8'(k));
        end
    endtask

    // Called right after a negedge; cycle n is sampled n negedges later.
    task automatic run_sb(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            if (n != 0) @(negedge clk);
            #1;
            for (int k = 0; k < sb.size(); ) begin
                if (sb[k].cyc == n) begin
                    chk(sb[k].tag, obs_of(sb[k].sel), sb[k].exp);
                    sb.delete(k);
                end else begin
                    k++;
                end
            end
        end
        chk("sb_leftover", 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_rs"}, 8'(rs), 8'(RegA));
        chk({pfx, "_rt"}, 8'(rt), 8'(RegA));
        chk({pfx, "_imm"}, imm, 8'h00);
        chk({pfx, "_aluop"}, 8'(alu_op), 8'(ALU_NOP));
        chk({pfx, "_regwr"}, 8'(reg_wr), 8'd0);
        chk({pfx, "_pcsrc"}, 8'(pc_src), 8'd0);
        chk({pfx, "_alusrc"}, 8'(alu_src), 8'd0);
        chk({pfx, "_m2r"}, 8'(mem_to_reg), 8'd0);
        chk({pfx, "_halted"}, 8'(halted), 8'd0);
        chk({pfx, "_illegal"}, 8'(illegal), 8'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            rom[i]  = 8'h00;
            dmem[i] = 8'h00;
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_mem();
        dmem[9] = 8'h5C;
        // 00: LI D,7A  02: ADDI B,5  04: ADD D,B  05: SUB B,D  06: LI A,9  08: LI C,9
        // 0A: BEQ A,C -> 20   20: LI C,8  22: BEQ A,C (not taken)  24: LW A  25: MOV C,D
        // 26: JMP 40   40: HALT
        rom[8'h00] = 8'h8C; rom[8'h01] = 8'h7A; rom[8'h02] = 8'h94; rom[8'h03] = 8'h05;
        rom[8'h04] = 8'h1D; rom[8'h05] = 8'h27; rom[8'h06] = 8'h80; rom[8'h07] = 8'h09;
        rom[8'h08] = 8'h88; rom[8'h09] = 8'h09; rom[8'h0A] = 8'hB2; rom[8'h0B] = 8'h20;
        rom[8'h20] = 8'h88; rom[8'h21] = 8'h08; rom[8'h22] = 8'hB2; rom[8'h23] = 8'h30;
        rom[8'h24] = 8'h70; rom[8'h25] = 8'h6B; rom[8'h26] = 8'hA0; rom[8'h27] = 8'h40;
        rom[8'h40] = 8'hF0;

        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst_pc", pc, 8'h00);

        // Release, then pull reset while the LI operand is being issued.
        rst = 1'b1;
        #1 chk("rel_pc", pc, 8'h00);
        @(negedge clk);
        #1;
        chk("simm_pc", pc, 8'h01);
        chk("simm_regwr", 8'(reg_wr), 8'd1);
        chk("simm_imm", imm, 8'h7A);
        rst = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_pc", pc, 8'h00);
        repeat (2) @(negedge clk);
        chk("midrst_nowr", rf_q[3], 8'h00);
        chk("midrst_pc2", pc, 8'h00);

        // Main program
        push_pc_run(0, 8'h00, 12, 1'b0);
        push_pc_run(12, 8'h20, 4, 1'b0);
        push_pc_run(16, 8'h24, 4, 1'b0);
        push_pc_run(20, 8'h40, 12, 1'b1);
        push(4, "li_d", SelD, 8'h7A);
        push(4, "addi_b", SelB, 8'h05);
        push(5, "add_d", SelD, 8'h7F);
        push(6, "sub_b", SelB, 8'h86);
        push(8, "li_a", SelA, 8'h09);
        push(10, "li_c", SelC, 8'h09);
        push(14, "li_c8", SelC, 8'h08);
        push(17, "lw_a", SelA, 8'h5C);
        push(18, "mov_c", SelC, 8'h7F);
        push(20, "halt_pre", SelHalt, 8'd0);
        for (int c = 21; c < 32; c++) begin
            push(c, "halted", SelHalt, 8'd1);
            push(c, "halt_wr", SelWr, 8'd0);
        end
        rst = 1'b1;
        run_sb(32);

        // Illegal opcode byte at 0x01
        rst = 1'b0;
        clear_mem();
        rom[8'h01] = 8'hC0;
        @(negedge clk);
        rst = 1'b1;
        push(0, "ill_pc", SelPc, 8'h00);
        push(1, "ill_pc", SelPc, 8'h01);
        push(1, "ill_halt", SelHalt, 8'd0);
        for (int c = 2; c < 7; c++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            push(c, "ill_pc", SelPc, 8'h01);
            push(c, "ill_halt", SelHalt, 8'd1);
            push(c, "ill_flag", SelIll, 8'd1);
`else
            push(c, "ill_pc", SelPc, 8'(c));
            push(c, "ill_halt", SelHalt, 8'd0);
            push(c, "ill_flag", SelIll, 8'd0);
`endif
        end
        run_sb(7);

        rst = 1'b0;
        #1;
        chk_idle("final_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
